// File: rtl/ram_dump_pkg.sv
// Shared types and constants for the RAM dump reader.
// Imported by the top level and the byte serializer.
package ram_dump_pkg;

    localparam int NB_BYTE        = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_STRIDE    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one RAM word and emits it as MSB-first bytes
// on a valid/ready interface.
module word_byte_serializer
    import ram_dump_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_word,
    input  logic               i_ready,
    output logic [NB_BYTE-1:0] o_byte,
    output logic               o_valid,
    output logic               o_word_done
);

    logic [NB_DATA-1:0] shreg_q, shreg_d;
    logic [1:0]         idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               hs;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            shreg_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        hs      = valid_q && i_ready;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (i_load) begin
            shreg_d = i_word;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (hs) begin
            shreg_d = shreg_q << NB_BYTE;
            idx_d   = idx_q + 2'd1;
            // last byte of the word: drop valid until the next load
            if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
                valid_d = 1'b0;
            end
        end
    end

    assign o_byte      = valid_q ? shreg_q[NB_DATA-1 -: NB_BYTE] : '0;
    assign o_valid     = valid_q;
    assign o_word_done = hs && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/ram_dump_reader.sv
// Dumps a range of RAM words as a byte stream, MSB first,
// for the debug UART transmitter.
module ram_dump_reader
    import ram_dump_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [NB_ADDR-1:0] i_base_addr,
    input  logic [NB_ADDR-1:0] i_num_words,
    output logic [NB_ADDR-1:0] o_ram_addr,
    input  logic [NB_DATA-1:0] i_ram_data,
    output logic [NB_BYTE-1:0] o_byte,
    output logic               o_byte_valid,
    input  logic               i_byte_ready,
    output logic               o_busy,
    output logic               o_done
);

    state_e             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_ADDR-1:0] words_q, words_d;
    logic               load;
    logic               word_done;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        words_d = words_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    addr_d  = i_base_addr;
                    words_d = i_num_words;
                    state_d = (i_num_words == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                load    = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (word_done) begin
                    // address wraps modulo 2^NB_ADDR by design
                    addr_d  = addr_q + NB_ADDR'(ADDR_STRIDE);
                    words_d = words_q - NB_ADDR'(1);
                    state_d = (words_q == NB_ADDR'(1)) ? DONE : LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_busy     = (state_q == LOAD) || (state_q == SEND);
    assign o_done     = (state_q == DONE);
    assign o_ram_addr = o_busy ? addr_q : '0;

    word_byte_serializer #(
        .NB_DATA (NB_DATA)
    ) u_ser (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_load      (load),
        .i_word      (i_ram_data),
        .i_ready     (i_byte_ready),
        .o_byte      (o_byte),
        .o_valid     (o_byte_valid),
        .o_word_done (word_done)
    );

endmodule

// File: tb/tb_ram_dump_reader.sv
// Directed bench for ram_dump_reader with a behavioural
// big-endian async-read RAM.
module tb_ram_dump_reader;

    logic       clk;
    logic       i_rst_n;
    logic       i_start;
    logic [7:0] i_base_addr;
    logic [7:0] i_num_words;
    logic [7:0] o_ram_addr;
    logic [31:0] i_ram_data;
    logic [7:0] o_byte;
    logic       o_byte_valid;
    logic       i_byte_ready;
    logic       o_busy;
    logic       o_done;

    logic [7:0] mem [256];
    logic [7:0] ra1, ra2, ra3;
    logic [7:0] exp_b [16];

    int n_checks;
    int n_fail;

    ram_dump_reader dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_num_words  (i_num_words),
        .o_ram_addr   (o_ram_addr),
        .i_ram_data   (i_ram_data),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .i_byte_ready (i_byte_ready),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ra1 = o_ram_addr + 8'd1;
    assign ra2 = o_ram_addr + 8'd2;
    assign ra3 = o_ram_addr + 8'd3;
    assign i_ram_data = {mem[o_ram_addr], mem[ra1], mem[ra2], mem[ra3]};

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"}, 32'(o_byte_valid), 32'd0);
        check_eq({tag, "_byte"}, 32'(o_byte), 32'd0);
        check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
        check_eq({tag, "_addr"}, 32'(o_ram_addr), 32'd0);
    endtask

    // rmode 0: ready always high; rmode 1: ready 1,0,0,1,0,0,...
    // inj >= 0: pulse a conflicting start in that cycle
    task automatic do_dump(input logic [7:0] base, input logic [7:0] num,
                           input int rmode, input int inj);
        int cyc, nb, first_v, last_hs, nload;
        logic pv, pr;
        logic [7:0] pb, ea;
        i_base_addr  = base;
        i_num_words  = num;
        i_start      = 1'b1;
        i_byte_ready = 1'b1;
        step();
        i_start = 1'b0;
        cyc = 0; nb = 0; first_v = -1; last_hs = -1; nload = 0;
        pv = 1'b0; pr = 1'b1; pb = 8'h00;
        while (o_done !== 1'b1 && cyc < 200) begin
            i_byte_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
            i_start = (cyc == inj);
            if (cyc == inj) begin
                i_base_addr = 8'h40;
                i_num_words = 8'd3;
            end
            if (pv && !pr) begin
                check_eq("hold_valid", 32'(o_byte_valid), 32'd1);
                check_eq("hold_byte", 32'(o_byte), 32'(pb));
            end
            if (!o_byte_valid) begin
                ea = base + 8'(4 * nload);
                check_eq("load_busy", 32'(o_busy), 32'd1);
                check_eq("load_addr", 32'(o_ram_addr), 32'(ea));
                check_eq("load_byte0", 32'(o_byte), 32'd0);
                nload++;
            end
            if (o_byte_valid && first_v < 0) first_v = cyc;
            if (o_byte_valid && i_byte_ready) begin
                check_eq("byte", 32'(o_byte), (nb < 16) ? 32'(exp_b[nb]) : 32'hFFFF);
                nb++;
                last_hs = cyc;
            end
            pv = o_byte_valid;
            pr = i_byte_ready;
            pb = o_byte;
            step();
            cyc++;
        end
        i_start = 1'b0;
        i_byte_ready = 1'b1;
        check_eq("done_seen", 32'(o_done), 32'd1);
        check_eq("nbytes", 32'(nb), 32'(4 * int'(num)));
        if (num != 8'd0) begin
            check_eq("first_valid_cyc", 32'(first_v), 32'd1);
            check_eq("done_after_last", 32'(cyc), 32'(last_hs + 1));
        end else begin
            check_eq("zero_done_cyc", 32'(cyc), 32'd0);
        end
        if (rmode == 0) check_eq("total_cycles", 32'(cyc), 32'(5 * int'(num)));
        check_eq("done_busy", 32'(o_busy), 32'd0);
        check_eq("done_addr", 32'(o_ram_addr), 32'd0);
        check_eq("done_valid", 32'(o_byte_valid), 32'd0);
        step();
        check_eq("done_pulse", 32'(o_done), 32'd0);
        check_idle("post");
    endtask

    task automatic load_seq();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h11 * ((i % 15) + 1));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_base_addr = 8'h00;
        i_num_words = 8'h00;
        i_byte_ready = 1'b1;
        load_seq();
        for (int i = 0; i < 16; i++) exp_b[i] = 8'h00;
        step();
        step();
        check_idle("reset");
        check_eq("reset_done", 32'(o_done), 32'd0);
        i_rst_n = 1'b1;
        step();

        // 1: two words, ready held high
        for (int i = 0; i < 8; i++) exp_b[i] = 8'(8'h11 * (i + 1));
        do_dump(8'h00, 8'd2, 0, -1);

        // 2: same dump under backpressure
        do_dump(8'h00, 8'd2, 1, -1);

        // 3: zero words
        do_dump(8'h00, 8'd0, 0, -1);

        // 6: conflicting start mid-dump is ignored
        do_dump(8'h00, 8'd2, 0, 3);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("no_restart_busy", 32'(o_busy), 32'd0);
            check_eq("no_restart_done", 32'(o_done), 32'd0);
        end

        // 5: reset during the 3rd byte of word 1
        i_base_addr = 8'h00;
        i_num_words = 8'd4;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        step();
        step();
        check_eq("pre_rst_byte", 32'(o_byte), 32'h33);
        check_eq("pre_rst_valid", 32'(o_byte_valid), 32'd1);
        i_rst_n = 1'b0;
        step();
        check_idle("midrst");
        check_eq("midrst_done", 32'(o_done), 32'd0);
        i_rst_n = 1'b1;
        step();
        check_idle("midrst_idle");
        for (int i = 0; i < 4; i++) exp_b[i] = 8'(8'h11 * (i + 1));
        do_dump(8'h00, 8'd1, 0, -1);

        // 4: address wrap 0xFC -> 0x00
        mem[8'hFC] = 8'hDE; mem[8'hFD] = 8'hAD;
        mem[8'hFE] = 8'hBE; mem[8'hFF] = 8'hEF;
        mem[8'h00] = 8'hCA; mem[8'h01] = 8'hFE;
        mem[8'h02] = 8'hF0; mem[8'h03] = 8'h0D;
        exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
        exp_b[4] = 8'hCA; exp_b[5] = 8'hFE; exp_b[6] = 8'hF0; exp_b[7] = 8'h0D;
        do_dump(8'hFC, 8'd2, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
